// File: rtl/pipe_alu_pkg.sv
// Shared constants for the forwarding ALU pipeline: operation codes and their width.
package pipe_alu_pkg;

    localparam int FN_W = 4;

    localparam logic [FN_W-1:0] FN_ADD  = 4'd0;
    localparam logic [FN_W-1:0] FN_SUB  = 4'd1;
    localparam logic [FN_W-1:0] FN_MUL  = 4'd2;
    localparam logic [FN_W-1:0] FN_SELA = 4'd3;
    localparam logic [FN_W-1:0] FN_SELB = 4'd4;
    localparam logic [FN_W-1:0] FN_AND  = 4'd5;
    localparam logic [FN_W-1:0] FN_OR   = 4'd6;
    localparam logic [FN_W-1:0] FN_XOR  = 4'd7;
    localparam logic [FN_W-1:0] FN_NEGA = 4'd8;
    localparam logic [FN_W-1:0] FN_NEGB = 4'd9;
    localparam logic [FN_W-1:0] FN_SRA  = 4'd10;
    localparam logic [FN_W-1:0] FN_SLA  = 4'd11;

endpackage

// File: rtl/pipe_alu_core.sv
// Combinational ALU: one result per func code, DW-bit wrap-around arithmetic.
module pipe_alu_core
    import pipe_alu_pkg::*;
#(
    parameter int DW = 16
)
(
    input  logic [FN_W-1:0] func,
    input  logic [DW-1:0]   a,
    input  logic [DW-1:0]   b,
    output logic [DW-1:0]   result
);

    // Operation decode; unassigned codes produce zero but are still written back.
    always_comb begin
        result = {DW{1'b0}};
        case (func)
            FN_ADD:  result = a + b;
            FN_SUB:  result = a - b;
            FN_MUL:  result = a * b;
            FN_SELA: result = a;
            FN_SELB: result = b;
            FN_AND:  result = a & b;
            FN_OR:   result = a | b;
            FN_XOR:  result = a ^ b;
            FN_NEGA: result = {DW{1'b0}} - a;
            FN_NEGB: result = {DW{1'b0}} - b;
            FN_SRA:  result = {1'b0, a[DW-1:1]};
            FN_SLA:  result = {a[DW-2:0], 1'b0};
            default: result = {DW{1'b0}};
        endcase
    end

endmodule

// File: rtl/pipe_alu_fwd.sv
// Two-stage regbank/ALU pipeline with operand forwarding, hold, valid signalling
// and a direct regbank configuration write port.
module pipe_alu_fwd
    import pipe_alu_pkg::*;
#(
    parameter int DW = 16,
    parameter int RA = 4,
    parameter int MA = 8
)
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic            hold,
    input  logic [RA-1:0]   rs1,
    input  logic [RA-1:0]   rs2,
    input  logic [RA-1:0]   rd,
    input  logic [FN_W-1:0] func,
    input  logic [MA-1:0]   addr,
    input  logic            cfg_we,
    input  logic [RA-1:0]   cfg_addr,
    input  logic [DW-1:0]   cfg_data,
    input  logic [MA-1:0]   mem_raddr,
    output logic [DW-1:0]   mem_rdata,
    output logic [DW-1:0]   Z,
    output logic            out_valid,
    output logic [RA-1:0]   out_rd
);

    localparam int NREG = 2 ** RA;
    localparam int NMEM = 2 ** MA;

    logic [DW-1:0]   regbank_r [NREG];
    logic [DW-1:0]   mem_r     [NMEM];

    logic            s1_valid_r;
    logic [DW-1:0]   s1_a_r;
    logic [DW-1:0]   s1_b_r;
    logic [FN_W-1:0] s1_func_r;
    logic [RA-1:0]   s1_rd_r;
    logic [MA-1:0]   s1_addr_r;

    logic            s2_valid_r;
    logic [DW-1:0]   s2_res_r;
    logic [RA-1:0]   s2_rd_r;
    logic [MA-1:0]   s2_addr_r;

    logic [DW-1:0]   z_r;
    logic            out_valid_r;
    logic [RA-1:0]   out_rd_r;

    logic [DW-1:0]   s1_res_s;
    logic [DW-1:0]   fwd_a_s;
    logic [DW-1:0]   fwd_b_s;
    logic            wb_s;

    pipe_alu_core #(.DW(DW)) u_core (
        .func   (s1_func_r),
        .a      (s1_a_r),
        .b      (s1_b_r),
        .result (s1_res_s)
    );

    // Operand A source: youngest in-flight producer first, then the regbank.
    always_comb begin
        fwd_a_s = regbank_r[rs1];
        if (s1_valid_r && (s1_rd_r == rs1)) begin
            fwd_a_s = s1_res_s;
        end else if (s2_valid_r && (s2_rd_r == rs1)) begin
            fwd_a_s = s2_res_r;
        end else begin
            fwd_a_s = regbank_r[rs1];
        end
    end

    // Operand B source, same priority as A.
    always_comb begin
        fwd_b_s = regbank_r[rs2];
        if (s1_valid_r && (s1_rd_r == rs2)) begin
            fwd_b_s = s1_res_s;
        end else if (s2_valid_r && (s2_rd_r == rs2)) begin
            fwd_b_s = s2_res_r;
        end else begin
            fwd_b_s = regbank_r[rs2];
        end
    end

    // Writeback only for a live S2 op on an advancing, non-reset edge.
    assign wb_s = s2_valid_r && !hold && !rst;

    // Pipeline control and result registers; hold freezes everything and drops the pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r  <= 1'b0;
            s2_valid_r  <= 1'b0;
            z_r         <= {DW{1'b0}};
            out_valid_r <= 1'b0;
            out_rd_r    <= {RA{1'b0}};
        end else if (hold) begin
            out_valid_r <= 1'b0;
        end else begin
            s1_valid_r  <= in_valid;
            s2_valid_r  <= s1_valid_r;
            out_valid_r <= s2_valid_r;
            if (s2_valid_r) begin
                z_r      <= s2_res_r;
                out_rd_r <= s2_rd_r;
            end else begin
                z_r      <= z_r;
                out_rd_r <= out_rd_r;
            end
        end
    end

    // Stage payloads; qualified by the valid bits so they need no reset.
    always_ff @(posedge clk) begin
        if (!hold) begin
            s1_a_r    <= fwd_a_s;
            s1_b_r    <= fwd_b_s;
            s1_func_r <= func;
            s1_rd_r   <= rd;
            s1_addr_r <= addr;
            s2_res_r  <= s1_res_s;
            s2_rd_r   <= s1_rd_r;
            s2_addr_r <= s1_addr_r;
        end
    end

    // Regbank writes; the pipeline write is last so it wins over a same-edge cfg write.
    always_ff @(posedge clk) begin
        if (cfg_we) begin
            regbank_r[cfg_addr] <= cfg_data;
        end
        if (wb_s) begin
            regbank_r[s2_rd_r] <= s2_res_r;
        end
    end

    // Result memory write.
    always_ff @(posedge clk) begin
        if (wb_s) begin
            mem_r[s2_addr_r] <= s2_res_r;
        end
    end

    assign mem_rdata = mem_r[mem_raddr];
    assign Z         = z_r;
    assign out_valid = out_valid_r;
    assign out_rd    = out_rd_r;

endmodule

// File: tb/tb_pipe_alu_fwd.sv
// Directed bench for pipe_alu_fwd: per-func vector table plus forwarding, hold,
// reset and cfg-collision sequences.
module tb_pipe_alu_fwd;
    import pipe_alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        hold;
    logic [3:0]  rs1, rs2, rd;
    logic [3:0]  func;
    logic [7:0]  addr;
    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic [15:0] cfg_data;
    logic [7:0]  mem_raddr;
    logic [15:0] mem_rdata;
    logic [15:0] Z;
    logic        out_valid;
    logic [3:0]  out_rd;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0]  func;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic [15:0] exp;
    } vec_t;

    typedef struct {
        logic [3:0] func;
        logic [3:0] rs1;
        logic [3:0] rs2;
        logic [3:0] rd;
        logic [7:0] addr;
    } op_t;

    vec_t tbl [14];
    op_t  ops [5];

    pipe_alu_fwd #(.DW(16), .RA(4), .MA(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .hold      (hold),
        .rs1       (rs1),
        .rs2       (rs2),
        .rd        (rd),
        .func      (func),
        .addr      (addr),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .mem_raddr (mem_raddr),
        .mem_rdata (mem_rdata),
        .Z         (Z),
        .out_valid (out_valid),
        .out_rd    (out_rd)
    );

    initial forever #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic issue(input logic [3:0] f, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] d, input logic [7:0] ad);
        in_valid = 1'b1;
        func     = f;
        rs1      = a;
        rs2      = b;
        rd       = d;
        addr     = ad;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic init_regs();
        for (int k = 0; k < 16; k++) begin
            cfg_we   = 1'b1;
            cfg_addr = 4'(k);
            cfg_data = 16'(k);
            tick();
        end
        cfg_we = 1'b0;
    endtask

    task automatic chk_mem(input string nm, input logic [7:0] a, input logic [15:0] exp);
        mem_raddr = a;
        #1;
        chk(nm, {16'h0000, mem_rdata}, {16'h0000, exp});
    endtask

    // Reads a register by passing it through SELA back into itself (value unchanged).
    task automatic chk_reg(input string nm, input logic [3:0] r, input logic [15:0] exp);
        issue(FN_SELA, r, 4'd0, r, 8'd255);
        tick();
        idle();
        tick();
        tick();
        chk(nm, {16'h0000, Z}, {16'h0000, exp});
    endtask

    initial begin
        tbl[0]  = '{FN_ADD,  4'd3,  4'd5,  16'd8};
        tbl[1]  = '{FN_SUB,  4'd3,  4'd5,  16'hFFFE};
        tbl[2]  = '{FN_MUL,  4'd6,  4'd7,  16'd42};
        tbl[3]  = '{FN_SELA, 4'd9,  4'd2,  16'd9};
        tbl[4]  = '{FN_SELB, 4'd9,  4'd2,  16'd2};
        tbl[5]  = '{FN_AND,  4'd12, 4'd10, 16'd8};
        tbl[6]  = '{FN_OR,   4'd12, 4'd10, 16'd14};
        tbl[7]  = '{FN_XOR,  4'd12, 4'd10, 16'd6};
        tbl[8]  = '{FN_NEGA, 4'd1,  4'd4,  16'hFFFF};
        tbl[9]  = '{FN_NEGB, 4'd0,  4'd4,  16'hFFFC};
        tbl[10] = '{FN_SRA,  4'd11, 4'd0,  16'd5};
        tbl[11] = '{FN_SLA,  4'd11, 4'd0,  16'd22};
        tbl[12] = '{4'd13,   4'd3,  4'd5,  16'd0};
        tbl[13] = '{4'd15,   4'd6,  4'd7,  16'd0};

        ops[0] = '{FN_ADD, 4'd3,  4'd5,  4'd10, 8'd160};
        ops[1] = '{FN_SUB, 4'd10, 4'd5,  4'd14, 8'd161};
        ops[2] = '{FN_MUL, 4'd3,  4'd8,  4'd12, 8'd162};
        ops[3] = '{FN_SLA, 4'd7,  4'd0,  4'd13, 8'd163};
        ops[4] = '{FN_ADD, 4'd12, 4'd13, 4'd0,  8'd164};

        rst = 1'b1; in_valid = 1'b0; hold = 1'b0;
        rs1 = 4'd0; rs2 = 4'd0; rd = 4'd0; func = 4'd0; addr = 8'd0;
        cfg_we = 1'b0; cfg_addr = 4'd0; cfg_data = 16'd0; mem_raddr = 8'd0;
        tick();
        tick();
        chk("reset Z", {16'h0000, Z}, 32'd0);
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset out_rd", {28'd0, out_rd}, 32'd0);
        rst = 1'b0;

        // Table: each func isolated, rd=15 never used as a source.
        init_regs();
        for (int i = 0; i < 14; i++) begin
            issue(tbl[i].func, tbl[i].rs1, tbl[i].rs2, 4'd15, 8'(200 + i));
            tick();
            idle();
            tick();
            chk($sformatf("vec%0d early valid", i), {31'd0, out_valid}, 32'd0);
            tick();
            chk($sformatf("vec%0d valid", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("vec%0d Z", i), {16'h0000, Z}, {16'h0000, tbl[i].exp});
            chk($sformatf("vec%0d out_rd", i), {28'd0, out_rd}, 32'd15);
            tick();
            chk($sformatf("vec%0d pulse end", i), {31'd0, out_valid}, 32'd0);
            chk_mem($sformatf("vec%0d mem", i), 8'(200 + i), tbl[i].exp);
        end

        // Single ADD with latency and writeback.
        init_regs();
        issue(FN_ADD, 4'd3, 4'd5, 4'd10, 8'd125);
        tick();
        idle();
        tick();
        chk("t1 valid k+1", {31'd0, out_valid}, 32'd0);
        tick();
        chk("t1 valid k+2", {31'd0, out_valid}, 32'd1);
        chk("t1 Z", {16'h0000, Z}, 32'd8);
        tick();
        chk("t1 pulse end", {31'd0, out_valid}, 32'd0);
        chk_mem("t1 mem125", 8'd125, 16'd8);
        chk_reg("t1 r10", 4'd10, 16'd8);

        // Back-to-back dependency through S1 forward.
        init_regs();
        issue(FN_ADD, 4'd3, 4'd5, 4'd10, 8'd125);
        tick();
        issue(FN_SUB, 4'd10, 4'd5, 4'd14, 8'd126);
        tick();
        idle();
        tick();
        chk("t2 Z first", {16'h0000, Z}, 32'd8);
        tick();
        chk("t2 Z second", {16'h0000, Z}, 32'd3);
        chk("t2 valid second", {31'd0, out_valid}, 32'd1);
        tick();
        chk_mem("t2 mem126", 8'd126, 16'd3);
        chk_reg("t2 r14", 4'd14, 16'd3);

        // S1 and S2 forwards on the same op.
        init_regs();
        issue(FN_MUL, 4'd3, 4'd8, 4'd12, 8'd128);
        tick();
        issue(FN_SLA, 4'd7, 4'd0, 4'd13, 8'd129);
        tick();
        issue(FN_ADD, 4'd12, 4'd13, 4'd0, 8'd130);
        tick();
        idle();
        chk("t3 Z mul", {16'h0000, Z}, 32'd24);
        tick();
        chk("t3 Z sla", {16'h0000, Z}, 32'd14);
        tick();
        chk("t3 Z add", {16'h0000, Z}, 32'd38);
        chk("t3 out_rd", {28'd0, out_rd}, 32'd0);
        tick();
        chk_mem("t3 mem130", 8'd130, 16'd38);
        chk_reg("t3 r0", 4'd0, 16'd38);

        // Stream with a two-cycle hold while the next op is presented.
        init_regs();
        begin
            logic [15:0] got [$];
            logic [15:0] exp_z [5];
            logic [15:0] last_z;
            int idx;
            exp_z = '{16'd8, 16'd3, 16'd24, 16'd14, 16'd38};
            idx = 0;
            last_z = 16'd0;
            for (int cyc = 0; cyc < 11; cyc++) begin
                hold = (cyc == 3 || cyc == 4);
                if (idx < 5) begin
                    issue(ops[idx].func, ops[idx].rs1, ops[idx].rs2, ops[idx].rd, ops[idx].addr);
                end else begin
                    idle();
                end
                tick();
                if (hold) begin
                    chk("t4 hold valid", {31'd0, out_valid}, 32'd0);
                    chk("t4 hold Z", {16'h0000, Z}, {16'h0000, last_z});
                end else begin
                    if (idx < 5) idx++;
                end
                if (out_valid) got.push_back(Z);
                last_z = Z;
            end
            hold = 1'b0;
            idle();
            chk("t4 result count", 32'(got.size()), 32'd5);
            for (int i = 0; i < 5; i++) begin
                if (i < got.size()) begin
                    chk($sformatf("t4 Z%0d", i), {16'h0000, got[i]}, {16'h0000, exp_z[i]});
                end else begin
                    chk($sformatf("t4 Z%0d missing", i), 32'd0, 32'd1);
                end
            end
            for (int i = 0; i < 5; i++) begin
                chk_mem($sformatf("t4 mem%0d", i), ops[i].addr, exp_z[i]);
            end
            chk_reg("t4 r10", 4'd10, 16'd8);
            chk_reg("t4 r14", 4'd14, 16'd3);
            chk_reg("t4 r12", 4'd12, 16'd24);
            chk_reg("t4 r13", 4'd13, 16'd14);
            chk_reg("t4 r0", 4'd0, 16'd38);
        end

        // Reset with two ops in flight: nothing may be written.
        init_regs();
        issue(FN_SELA, 4'd7, 4'd0, 4'd7, 8'd140);
        tick();
        issue(FN_SELA, 4'd7, 4'd0, 4'd7, 8'd141);
        tick();
        idle();
        tick();
        tick();
        tick();
        issue(FN_ADD, 4'd3, 4'd5, 4'd9, 8'd140);
        tick();
        issue(FN_SUB, 4'd3, 4'd5, 4'd11, 8'd141);
        tick();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5 valid", {31'd0, out_valid}, 32'd0);
        chk("t5 Z", {16'h0000, Z}, 32'd0);
        chk("t5 out_rd", {28'd0, out_rd}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5 valid after", {31'd0, out_valid}, 32'd0);
        end
        chk_mem("t5 mem140", 8'd140, 16'd7);
        chk_mem("t5 mem141", 8'd141, 16'd7);
        chk_reg("t5 r9", 4'd9, 16'd9);
        chk_reg("t5 r11", 4'd11, 16'd11);

        // Cfg-written operands, null func, and cfg/pipeline collision.
        init_regs();
        cfg_we = 1'b1; cfg_addr = 4'd1; cfg_data = 16'hFFFF;
        tick();
        cfg_we = 1'b0;
        issue(FN_MUL, 4'd1, 4'd2, 4'd4, 8'd150);
        tick();
        issue(4'd12, 4'd3, 4'd5, 4'd6, 8'd151);
        tick();
        idle();
        tick();
        chk("t6 mul wrap", {16'h0000, Z}, 32'h0000FFFE);
        tick();
        chk("t6 func12", {16'h0000, Z}, 32'd0);
        chk("t6 func12 valid", {31'd0, out_valid}, 32'd1);
        tick();
        chk_mem("t6 mem151", 8'd151, 16'd0);
        issue(FN_SELA, 4'd9, 4'd0, 4'd5, 8'd152);
        tick();
        idle();
        tick();
        cfg_we = 1'b1; cfg_addr = 4'd5; cfg_data = 16'h1234;
        tick();
        cfg_we = 1'b0;
        chk("t6 collide Z", {16'h0000, Z}, 32'd9);
        chk_reg("t6 r5 pipeline wins", 4'd5, 16'd9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
